// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 raster constants and glyph geometry for the glyph-mode pipeline.
`ifndef VGA_TIMING_GEN_PKG_SV
`define VGA_TIMING_GEN_PKG_SV
package vga_timing_gen_pkg;

    localparam int CNT_W     = 10;
    localparam int ROW_DIV_W = 7;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int GLYPH_H = 12;
    localparam int ROWS    = 40;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage
`endif

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter with sync-window and active-region decode.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             active
);

    localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

    // Decodes compare in 32 bits so a window ending exactly at 1024 cannot alias.
    assign wrap   = (int'(count) == TOTAL - 1);
    assign sync   = (int'(count) >= SYNC_START) && (int'(count) < SYNC_END);
    assign active = (int'(count) < ACTIVE);

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator; registers all outputs from the same pixel.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    output logic [CNT_W-1:0]     hpos,
    output logic [CNT_W-1:0]     vpos,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [ROW_DIV_W-1:0] row_div4
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > (1 << CNT_W)) begin : g_h_range
        $error("vga_timing_gen: H_TOTAL does not fit the position counter");
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_v_range
        $error("vga_timing_gen: V_TOTAL does not fit the position counter");
    end
    if ((V_ACTIVE - 1) / 4 >= (1 << ROW_DIV_W)) begin : g_row_range
        $error("vga_timing_gen: active lines overflow the row dividend");
    end
    if (VGA_V_ACTIVE != GLYPH_H * ROWS) begin : g_glyph_geom
        $error("vga_timing_gen: glyph geometry does not tile the active area");
    end

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_sync;
    logic             v_sync;
    logic             h_act;
    logic             v_act;
    logic             at_origin;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk(clk), .reset(reset), .advance(ce),
        .count(h), .wrap(h_wrap), .sync(h_sync), .active(h_act)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk(clk), .reset(reset), .advance(ce & h_wrap),
        .count(v), .wrap(v_wrap), .sync(v_sync), .active(v_act)
    );

    // at_origin tracks "counters sit at (0,0)" so frame_start needs no wide compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos        <= '0;
            vpos        <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            row_div4    <= '0;
            at_origin   <= 1'b1;
        end else if (ce) begin
            hpos        <= h;
            vpos        <= v;
            hsync       <= h_sync ? SYNC_POL : ~SYNC_POL;
            vsync       <= v_sync ? SYNC_POL : ~SYNC_POL;
            de          <= h_act && v_act;
            line_start  <= (h == '0);
            frame_start <= at_origin;
            row_div4    <= v_act ? v[ROW_DIV_W+1:2] : '0;
            at_origin   <= h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-width raster (full frames) and a full 640x480 raster,
// both checked every cycle against an arithmetic pixel-index model plus a table of fixed points.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       hsync;
        logic       vsync;
        logic       de;
        logic       line_start;
        logic       frame_start;
        logic [6:0] row_div4;
    } out_t;

    typedef struct {
        int   big;
        int   pix;
        out_t want;
    } vec_t;

    localparam int SH_A    = 16;
    localparam int SH_F    = 2;
    localparam int SH_S    = 4;
    localparam int SH_B    = 3;
    localparam int SH_T    = SH_A + SH_F + SH_S + SH_B;
    localparam int V_T     = 525;
    localparam int FRAME_S = SH_T * V_T;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic ce    = 1'b0;

    logic [9:0] s_hpos, s_vpos, b_hpos, b_vpos;
    logic       s_hsync, s_vsync, s_de, s_ls, s_fs;
    logic       b_hsync, b_vsync, b_de, b_ls, b_fs;
    logic [6:0] s_row, b_row;
    out_t       s_out, b_out;

    assign s_out = {s_hpos, s_vpos, s_hsync, s_vsync, s_de, s_ls, s_fs, s_row};
    assign b_out = {b_hpos, b_vpos, b_hsync, b_vsync, b_de, b_ls, b_fs, b_row};

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B)
    ) dut_small (
        .clk(clk), .reset(reset), .ce(ce),
        .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
        .line_start(s_ls), .frame_start(s_fs), .row_div4(s_row)
    );

    vga_timing_gen dut_big (
        .clk(clk), .reset(reset), .ce(ce),
        .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
        .line_start(b_ls), .frame_start(b_fs), .row_div4(b_row)
    );

    always #5 clk = ~clk;

    int   k = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    int   tbl_idx = 0;
    bit   tbl_en = 1'b0;
    bit   mon_en = 1'b0;
    int   mult = 1;
    bit   frame_open;
    int   frames, period, de_cnt, hs_cnt, vs_cnt, s_run, b_run;
    logic prev_fs, prev_vs, prev_shs, prev_bhs;

    // Expected outputs after kk enabled edges: pixel kk-1 of an endless raster scan.
    function automatic out_t model(input int ha, input int hf, input int hs, input int hb, input int kk);
        out_t o;
        int   ht, p, h, v;
        o = '0;
        o.hsync = 1'b1;
        o.vsync = 1'b1;
        if (kk == 0) return o;
        ht = ha + hf + hs + hb;
        p  = (kk - 1) % (ht * V_T);
        h  = p % ht;
        v  = p / ht;
        o.hpos        = 10'(h);
        o.vpos        = 10'(v);
        o.hsync       = !(h >= ha + hf && h < ha + hf + hs);
        o.vsync       = !(v >= 490 && v < 492);
        o.de          = (h < ha) && (v < 480);
        o.line_start  = (h == 0);
        o.frame_start = (p == 0);
        o.row_div4    = (v < 480) ? 7'(v / 4) : 7'd0;
        return o;
    endfunction

    function automatic vec_t mk(input int big, input int pix, input int hp, input int vp, input int hs,
                                input int vs, input int de, input int ls, input int fs, input int row);
        vec_t r;
        r.big              = big;
        r.pix              = pix;
        r.want.hpos        = 10'(hp);
        r.want.vpos        = 10'(vp);
        r.want.hsync       = (hs != 0);
        r.want.vsync       = (vs != 0);
        r.want.de          = (de != 0);
        r.want.line_start  = (ls != 0);
        r.want.frame_start = (fs != 0);
        r.want.row_div4    = 7'(row);
        return r;
    endfunction

    task automatic compareOut(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s k=%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b row=%0d want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b row=%0d",
                     name, k, got.hpos, got.vpos, got.hsync, got.vsync, got.de, got.line_start,
                     got.frame_start, got.row_div4, want.hpos, want.vpos, want.hsync, want.vsync,
                     want.de, want.line_start, want.frame_start, want.row_div4);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s k=%0d got=%0d want=%0d", name, k, got, want);
        end
    endtask

    task automatic checkOutput();
        out_t got;
        compareOut("model_small", s_out, model(SH_A, SH_F, SH_S, SH_B, k));
        compareOut("model_big", b_out, model(640, 16, 96, 48, k));
        while (tbl_en && tbl_idx < tbl.size() && tbl[tbl_idx].pix == k - 1) begin
            got = tbl[tbl_idx].big != 0 ? b_out : s_out;
            compareOut(tbl[tbl_idx].big != 0 ? "table_big" : "table_small", got, tbl[tbl_idx].want);
            checkInt("glyph_row", int'(got.row_div4) / 3,
                     (int'(got.vpos) < 480) ? int'(got.vpos) / 12 : 0);
            tbl_idx++;
        end
    endtask

    task automatic monitorReset(input int m);
        mult       = m;
        frame_open = 1'b0;
        frames     = 0;
        s_run      = 0;
        b_run      = 0;
        prev_fs    = 1'b0;
        prev_vs    = 1'b1;
        prev_shs   = 1'b1;
        prev_bhs   = 1'b1;
    endtask

    // Frame-level statistics on the small raster, sync-pulse placement on both rasters.
    task automatic monitor();
        if (s_out.frame_start && !prev_fs) begin
            if (frame_open) begin
                checkInt("frame_period", period, FRAME_S * mult);
                checkInt("de_per_frame", de_cnt, SH_A * 480 * mult);
                checkInt("hsync_low_per_frame", hs_cnt, SH_S * V_T * mult);
                checkInt("vsync_low_per_frame", vs_cnt, 2 * SH_T * mult);
                frames++;
            end
            frame_open = 1'b1;
            period = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        end
        if (frame_open) begin
            period++;
            de_cnt += int'(s_out.de);
            hs_cnt += int'(!s_out.hsync);
            vs_cnt += int'(!s_out.vsync);
        end
        if (!s_out.vsync && prev_vs) begin
            checkInt("vsync_fall_vpos", int'(s_out.vpos), 490);
            checkInt("vsync_fall_hpos", int'(s_out.hpos), 0);
        end
        if (s_out.vsync && !prev_vs) begin
            checkInt("vsync_rise_vpos", int'(s_out.vpos), 492);
            checkInt("vsync_rise_hpos", int'(s_out.hpos), 0);
        end
        if (!s_out.hsync && prev_shs) checkInt("hsync_start_small", int'(s_out.hpos), SH_A + SH_F);
        if (s_out.hsync && !prev_shs) checkInt("hsync_width_small", s_run, SH_S * mult);
        s_run = s_out.hsync ? 0 : s_run + 1;
        if (!b_out.hsync && prev_bhs) checkInt("hsync_start_big", int'(b_out.hpos), 656);
        if (b_out.hsync && !prev_bhs) checkInt("hsync_width_big", b_run, 96 * mult);
        b_run = b_out.hsync ? 0 : b_run + 1;
        prev_fs  = s_out.frame_start;
        prev_vs  = s_out.vsync;
        prev_shs = s_out.hsync;
        prev_bhs = b_out.hsync;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) k = 0;
        else if (ce) k++;
        @(negedge clk);
        checkOutput();
        if (mon_en) monitor();
    endtask

    task automatic applyStimulus(input logic ce_v, input logic rst_v);
        ce    = ce_v;
        reset = rst_v;
        tick();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired k=%0d", k);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   guard;
        logic c;

        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 17, 17, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 18, 18, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 21, 21, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 22, 22, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 25, 0, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 100, 0, 4, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 280, 5, 11, 1, 1, 1, 0, 0, 2));
        tbl.push_back(mk(0, 300, 0, 12, 1, 1, 1, 1, 0, 3));
        tbl.push_back(mk(1, 639, 639, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 640, 640, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 655, 655, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 656, 656, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 751, 751, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 752, 752, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 799, 799, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 800, 0, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 11990, 15, 479, 1, 1, 1, 0, 0, 119));
        tbl.push_back(mk(0, 11991, 16, 479, 1, 1, 0, 0, 0, 119));
        tbl.push_back(mk(0, 12000, 0, 480, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 12249, 24, 489, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 12250, 0, 490, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 12299, 24, 491, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 12300, 0, 492, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 13000, 0, 520, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 13124, 24, 524, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 13125, 0, 0, 1, 1, 1, 1, 1, 0));

        // Continuous ce: one full small frame plus the first lines of the full raster.
        $display("[TB] continuous ce run");
        monitorReset(1);
        tbl_en = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b1);
        mon_en = 1'b1;
        while (k < FRAME_S + 1) applyStimulus(1'b1, 1'b0);
        checkInt("frames_ce1", frames, 1);
        checkInt("table_coverage", tbl_idx, tbl.size());
        tbl_en = 1'b0;
        mon_en = 1'b0;

        // ce alternating 1-0-1: every statistic stretches by two clocks per pixel.
        $display("[TB] alternating ce run");
        repeat (2) applyStimulus(1'b0, 1'b1);
        monitorReset(2);
        mon_en = 1'b1;
        c = 1'b1;
        while (k < FRAME_S + 1) begin
            applyStimulus(c, 1'b0);
            c = ~c;
        end
        checkInt("frames_ce_alt", frames, 1);
        mon_en = 1'b0;

        // Random ce up to pixel (10,200) of the small raster, then an asynchronous reset.
        $display("[TB] random ce run with mid-frame reset");
        repeat (2) applyStimulus(1'b0, 1'b1);
        guard = 0;
        while (k < 5011 && guard < 20000) begin
            applyStimulus(logic'($urandom_range(3) != 0), 1'b0);
            guard++;
        end
        checkInt("reach_reset_point", k, 5011);
        checkInt("pre_reset_hpos", int'(s_out.hpos), 10);
        checkInt("pre_reset_vpos", int'(s_out.vpos), 200);
        #2;
        reset = 1'b1;
        #1;
        k = 0;
        compareOut("async_reset_small", s_out, model(SH_A, SH_F, SH_S, SH_B, 0));
        compareOut("async_reset_big", b_out, model(640, 16, 96, 48, 0));
        repeat (3) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkInt("restart_frame_start", int'(s_out.frame_start), 1);
        checkInt("restart_hpos", int'(b_out.hpos), 0);
        checkInt("restart_vpos", int'(b_out.vpos), 0);
        repeat (600) applyStimulus(logic'($urandom_range(1) != 0), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
